// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add sequencer.
// Nibble width and FSM state encoding.
package wide_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wadd_state_t;

endpackage

// File: rtl/wide_add_sequencer_nibble_adder.sv
// 4-bit ripple-carry adder built from full-adder cells.
// Also exports the carry into bit 3 for signed overflow.
module nibble_adder
    import wide_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);

    logic carry;

    // Full-adder cells chained LSB to MSB.
    always_comb begin
        s     = '0;
        c3    = 1'b0;
        carry = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            if (i == NIBBLE_W - 1) begin
                c3 = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor over one shared nibble adder.
// Valid/ready on both sides, one transaction in flight.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*WORDS-1:0] a,
    input  logic [4*WORDS-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               busy
);

    localparam int N  = NIBBLE_W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    wadd_state_t state_q;
    wadd_state_t state_d;

    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  sum_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic          cout_q;
    logic          ovf_q;

    logic [NIBBLE_W-1:0] a_cur;
    logic [NIBBLE_W-1:0] b_cur;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_co;
    logic                nib_c3;
    logic                last;

    assign last      = (idx_q == LAST_IDX);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Select the current operand nibbles by index.
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                a_cur = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_cur = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_adder u_nib (
        .a  (a_cur),
        .b  (b_cur),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; handshakes depend only on state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (last)     state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and one nibble per cycle of accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx_q == IW'(i)) begin
                            sum_q[i*NIBBLE_W +: NIBBLE_W] <= nib_s;
                        end
                    end
                    carry_q <= nib_co;
                    idx_q   <= idx_q + IW'(1);
                    if (last) begin
                        cout_q <= nib_co;
                        ovf_q  <= nib_c3 ^ nib_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer, WORDS=4.
// Hand-computed vectors, one task per scenario.
module tb_wide_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    wide_add_sequencer #(.WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tcin, input logic tsub,
                           input logic [15:0] es, input logic ec,
                           input logic eo, input bit toggle,
                           input string nm);
        int cyc;
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s in_ready: got %b want 1", nm, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            if (toggle) begin
                a = ~a; b = b ^ 16'h5A5A; sub = ~sub; cin = ~cin;
            end
            @(posedge clk); #1;
            cyc++;
        end
        compared++;
        if (cyc != 4) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want 4", nm, cyc);
        end
        compared++;
        if ({sum, cout, ovf} !== {es, ec, eo}) begin
            mismatched++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     nm, sum, cout, ovf, es, ec, eo);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        compared++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            mismatched++;
            $display("FAIL %s release: got ov/ir/busy=%b%b%b want 010",
                     nm, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
            mismatched++;
            $display("FAIL reset: got ir/ov/busy=%b%b%b sum=%h cout=%b ovf=%b want 100 0000 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_txn(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0, "basic_add");
        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "ripple_b1");
        run_txn(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "ripple_cin");
        run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "signed_ovf");
    endtask

    task automatic test_sub();
        run_txn(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, "sub_borrow");
        run_txn(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "sub_ovf");
    endtask

    task automatic test_input_changes();
        run_txn(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1, "input_toggle");
    endtask

    task automatic test_backpressure();
        int cyc;
        a = 16'h1234; b = 16'h0F0F; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        compared++;
        if (cyc != 4) begin
            mismatched++;
            $display("FAIL bp latency: got %0d want 4", cyc);
        end
        a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            compared++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {2'b10, 16'h2143, 2'b00}) begin
                mismatched++;
                $display("FAIL bp hold %0d: got ov/ir=%b%b sum=%h cout=%b ovf=%b want 10 2143 0 0",
                         k, out_valid, in_ready, sum, cout, ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        compared++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            mismatched++;
            $display("FAIL bp release: got ir/busy/ov=%b%b%b want 100",
                     in_ready, busy, out_valid);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL bp no_accept: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        compared++;
        if ({busy, sum} !== {1'b1, 16'h0045}) begin
            mismatched++;
            $display("FAIL midrun partial: got busy=%b sum=%h want 1 0045", busy, sum);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
            mismatched++;
            $display("FAIL midrun reset: got ir/ov/busy=%b%b%b sum=%h cout=%b ovf=%b want 100 0000 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        compared++;
        if ({busy, out_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL midrun discard: got busy/ov=%b%b want 00", busy, out_valid);
        end
        run_txn(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_input_changes();
        test_backpressure();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
